// File: rtl/debug_dma_host_cmd_if.sv
// Host link stream bundle for the debug DMA command front end.
// RX carries host command/data words in, TX carries response words out.
interface debug_dma_host_cmd_if;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // Host side: produces RX words, consumes TX words.
  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  // Command front end side.
  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/debug_dma_host_cmd.sv
// Host command parser for the debug DMA: header/address/data words in, per-thread
// register writes out, write-buffer readback or ack on TX. Optional: DEBUG_DMA_PARITY_EN.
module debug_dma_host_cmd #(
  parameter int NTHREADIDMSB = 5,
  parameter int DMABUFMSB    = 9
) (
  input  logic                       gclk,
  input  logic                       rst,
  debug_dma_host_cmd_if.slave        host,
  output logic [NTHREADIDMSB:0]      cmd_tid,
  output logic [30:0]                cmd_addr_reg,
  output logic                       cmd_addr_we,
  output logic [2*(DMABUFMSB+1)+1:0] cmd_ctrl_reg,
  output logic                       cmd_ctrl_we,
  output logic [DMABUFMSB:0]         rbuf_addr,
  output logic                       rbuf_we,
  output logic [31:0]                rbuf_data,
  output logic [DMABUFMSB:0]         wbuf_addr,
  input  logic [31:0]                wbuf_data,
  input  logic                       wbuf_parity,
  input  logic                       dma_done,
  input  logic [NTHREADIDMSB:0]      dma_done_tid,
  output logic                       busy,
  output logic                       err
);

  localparam int TW      = NTHREADIDMSB + 1;
  localparam int BW      = DMABUFMSB + 1;
  localparam int TID_LSB = 30 - TW;
  localparam int BUF_LSB = TID_LSB - BW;
  localparam int CNT_LSB = BUF_LSB - BW;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [31:4]   r_hdr;
  logic [29:0]   r_addr;
  logic [BW-1:0] r_ptr;
  logic [BW-1:0] r_cnt;
  logic          r_pend;
  logic          r_all_loaded;
  logic          r_tx_valid;
  logic [31:0]   r_tx_data;
  logic          r_err;

  logic          w_rx_open;
  logic          w_rx_fire;
  logic          w_tx_fire;
  logic [1:0]    w_rx_op;
  logic          w_is_write;
  logic          w_cmd;
  logic [TW-1:0] w_tid;
  logic [BW-1:0] w_buf;
  logic [BW-1:0] w_cnt;
  logic          w_load;
  logic          w_load_last;
  logic          w_err_set;
  logic          w_addr_par;
  logic          w_ctrl_par;

  assign w_rx_op    = host.rx_data[31:30];
  assign w_rx_fire  = host.rx_valid && host.rx_ready;
  assign w_tx_fire  = r_tx_valid && host.tx_ready;
  assign w_is_write = (r_hdr[31:30] == OP_WRITE);
  assign w_cmd      = r_hdr[30];
  assign w_tid      = r_hdr[TID_LSB +: TW];
  assign w_buf      = r_hdr[BUF_LSB +: BW];
  assign w_cnt      = r_hdr[CNT_LSB +: BW];

`ifdef DEBUG_DMA_PARITY_EN
  assign w_addr_par = ^r_addr;
  assign w_ctrl_par = ^{w_buf, w_cnt, w_cmd};
`else
  logic w_unused;
  assign w_unused   = wbuf_parity;
  assign w_addr_par = 1'b0;
  assign w_ctrl_par = 1'b0;
`endif

  // State register
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rx_fire && (w_rx_op == OP_WRITE || w_rx_op == OP_READ)) begin
          w_state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_rx_fire) begin
          w_state_next = w_is_write ? S_WDATA : S_ISSUE;
        end
      end
      S_WDATA: begin
        if (w_rx_fire && r_cnt == '0) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        if (dma_done && dma_done_tid == w_tid) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (w_tx_fire && r_all_loaded) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_rx_open   = 1'b0;
    cmd_addr_we = 1'b0;
    cmd_ctrl_we = 1'b0;
    rbuf_we     = 1'b0;
    rbuf_data   = '0;
    w_load      = 1'b0;
    w_load_last = 1'b0;
    w_err_set   = 1'b0;
    wbuf_addr   = r_ptr;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        w_rx_open = 1'b1;
        w_err_set = w_rx_fire && (w_rx_op == OP_RSVD);
      end
      S_ADDR:  w_rx_open = 1'b1;
      S_WDATA: begin
        w_rx_open = 1'b1;
        rbuf_we   = w_rx_fire;
        rbuf_data = w_rx_fire ? host.rx_data : 32'h0;
      end
      S_ISSUE: begin
        cmd_addr_we = 1'b1;
        cmd_ctrl_we = 1'b1;
      end
      S_RESP: begin
        if (!r_all_loaded) begin
          if (w_is_write) begin
            w_load      = 1'b1;
            w_load_last = 1'b1;
          end else if (r_pend && (!r_tx_valid || host.tx_ready)) begin
            w_load      = 1'b1;
            w_load_last = (r_cnt == '0);
          end
        end
        // Advance the read address only when the current word is taken; a
        // stalled word is simply re-read from the same address.
        if (!w_is_write && w_load && !w_load_last) begin
          wbuf_addr = r_ptr + 1'b1;
        end
`ifdef DEBUG_DMA_PARITY_EN
        w_err_set = w_load && !w_is_write && ((^wbuf_data) != wbuf_parity);
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      r_hdr        <= '0;
      r_addr       <= '0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_pend       <= 1'b0;
      r_all_loaded <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_rx_fire && (w_rx_op == OP_WRITE || w_rx_op == OP_READ)) begin
            r_hdr <= host.rx_data[31:4];
            r_ptr <= host.rx_data[BUF_LSB +: BW];
            r_cnt <= host.rx_data[CNT_LSB +: BW];
          end
        end
        S_ADDR: begin
          if (w_rx_fire) begin
            r_addr <= host.rx_data[31:2];
          end
        end
        S_WDATA: begin
          if (w_rx_fire) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ISSUE: begin
          r_ptr        <= w_buf;
          r_cnt        <= w_cnt;
          r_pend       <= 1'b0;
          r_all_loaded <= 1'b0;
        end
        S_RESP: begin
          // First RESP cycle presents buf_addr; data is usable from the next cycle.
          if (!w_is_write && !r_pend && !r_all_loaded) begin
            r_pend <= 1'b1;
          end
          if (w_load) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_is_write ? {r_hdr, 4'h0} : wbuf_data;
            if (!w_is_write) begin
              r_ptr  <= r_ptr + 1'b1;
              r_cnt  <= r_cnt - 1'b1;
              r_pend <= !w_load_last;
            end
            if (w_load_last) begin
              r_all_loaded <= 1'b1;
            end
          end else if (w_tx_fire) begin
            r_tx_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign host.rx_ready = w_rx_open && !rst;
  assign host.tx_valid = r_tx_valid;
  assign host.tx_data  = r_tx_data;
  assign rbuf_addr     = r_ptr;
  assign cmd_tid       = w_tid;
  assign cmd_addr_reg  = {r_addr, w_addr_par};
  assign cmd_ctrl_reg  = {w_buf, w_cnt, w_cmd, w_ctrl_par};
  assign err           = r_err;

endmodule

// File: tb/tb_debug_dma_host_cmd.sv
// Directed bench for debug_dma_host_cmd: write/read commands, tid filtering,
// reserved op, mid-op reset and parity (DEBUG_DMA_PARITY_EN aware).
module tb_debug_dma_host_cmd;
  logic        gclk;
  logic        rst;
  logic [5:0]  cmd_tid;
  logic [30:0] cmd_addr_reg;
  logic        cmd_addr_we;
  logic [21:0] cmd_ctrl_reg;
  logic        cmd_ctrl_we;
  logic [9:0]  rbuf_addr;
  logic        rbuf_we;
  logic [31:0] rbuf_data;
  logic [9:0]  wbuf_addr;
  logic [31:0] wbuf_data;
  logic        wbuf_parity;
  logic        dma_done;
  logic [5:0]  dma_done_tid;
  logic        busy;
  logic        err;

  debug_dma_host_cmd_if hif();

  debug_dma_host_cmd dut (
    .gclk(gclk), .rst(rst), .host(hif),
    .cmd_tid(cmd_tid), .cmd_addr_reg(cmd_addr_reg), .cmd_addr_we(cmd_addr_we),
    .cmd_ctrl_reg(cmd_ctrl_reg), .cmd_ctrl_we(cmd_ctrl_we),
    .rbuf_addr(rbuf_addr), .rbuf_we(rbuf_we), .rbuf_data(rbuf_data),
    .wbuf_addr(wbuf_addr), .wbuf_data(wbuf_data), .wbuf_parity(wbuf_parity),
    .dma_done(dma_done), .dma_done_tid(dma_done_tid), .busy(busy), .err(err)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Write-buffer model with one-cycle registered read
  logic [31:0] wmem [1024];
  logic        pflip [1024];
  initial begin
    for (int i = 0; i < 1024; i++) begin
      wmem[i]  = 32'hA5C3_0000 | 32'(i);
      pflip[i] = 1'b0;
    end
  end
  always @(posedge gclk) begin
    wbuf_data   <= wmem[wbuf_addr];
    wbuf_parity <= (^wmem[wbuf_addr]) ^ pflip[wbuf_addr];
  end

  // Observation, sampled mid-cycle after the negedge drive has settled
  int          cyc = 0;
  int          issue_cnt = 0;
  int          strobe_split = 0;
  int          stall_viol = 0;
  logic [30:0] cap_addr;
  logic [21:0] cap_ctrl;
  logic [5:0]  cap_tid;
  logic [41:0] rbq [$];
  logic [31:0] txq [$];
  int          txcyc [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  always begin
    @(negedge gclk);
    #2;
    cyc++;
    if (cmd_addr_we) begin
      issue_cnt++;
      cap_addr = cmd_addr_reg;
      cap_ctrl = cmd_ctrl_reg;
      cap_tid  = cmd_tid;
    end
    if (cmd_addr_we != cmd_ctrl_we) strobe_split++;
    if (rbuf_we) rbq.push_back({rbuf_addr, rbuf_data});
    if (prev_stall && (!hif.tx_valid || hif.tx_data != prev_data)) stall_viol++;
    if (hif.tx_valid && hif.tx_ready) begin
      txq.push_back(hif.tx_data);
      txcyc.push_back(cyc);
    end
    prev_stall = hif.tx_valid && !hif.tx_ready && !rst;
    prev_data  = hif.tx_data;
  end

  task automatic clear_logs();
    rbq.delete();
    txq.delete();
    txcyc.delete();
    issue_cnt = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int k;
    k = 0;
    hif.rx_data  = w;
    hif.rx_valid = 1'b1;
    while (!hif.rx_ready && k < 50) begin
      @(negedge gclk);
      k++;
    end
    @(negedge gclk);
    hif.rx_valid = 1'b0;
    hif.rx_data  = '0;
    n_tests++;
    if (k >= 50) begin
      n_fail++;
      $display("FAIL rx_accept: word %h not accepted in 50 cycles, rx_ready required 1", w);
    end
  endtask

  task automatic pulse_done(input logic [5:0] tid);
    dma_done     = 1'b1;
    dma_done_tid = tid;
    @(negedge gclk);
    dma_done     = 1'b0;
  endtask

  task automatic collect_tx(input int n, input bit rnd);
    int k;
    k = 0;
    while (txq.size() < n && k < 300) begin
      hif.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge gclk);
      k++;
    end
    hif.tx_ready = 1'b0;
    n_tests++;
    if (txq.size() != n) begin
      n_fail++;
      $display("FAIL tx_count: got %0d words, required %0d", txq.size(), n);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 50) begin
      @(negedge gclk);
      k++;
    end
    n_tests++;
    if (busy !== 1'b0 || hif.rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_return: busy=%b rx_ready=%b, required 0/1", busy, hif.rx_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge gclk);
    @(negedge gclk);
    n_tests++;
    if ({hif.rx_ready, hif.tx_valid, busy, err, cmd_addr_we, cmd_ctrl_we, rbuf_we} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy/txv/busy/err/awe/cwe/rwe=%b, required 0000000",
               {hif.rx_ready, hif.tx_valid, busy, err, cmd_addr_we, cmd_ctrl_we, rbuf_we});
    end
    rst = 1'b0;
    @(negedge gclk);
    n_tests++;
    if (hif.rx_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: rx_ready=%b busy=%b, required 1/0", hif.rx_ready, busy);
    end
  endtask

  task automatic test_write();
    logic [41:0] exp_rb [3];
    exp_rb[0] = {10'd0, 32'hAAAA_0001};
    exp_rb[1] = {10'd1, 32'hBBBB_0002};
    exp_rb[2] = {10'd2, 32'hCCCC_0003};
    clear_logs();
    send_word(32'h4300_002A);
    send_word(32'h4000_0010);
    send_word(32'hAAAA_0001);
    send_word(32'hBBBB_0002);
    send_word(32'hCCCC_0003);
    repeat (4) @(negedge gclk);
    n_tests++;
    if (rbq.size() != 3) begin
      n_fail++;
      $display("FAIL write_rbuf_count: got %0d, required 3", rbq.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (i >= rbq.size() || rbq[i] !== exp_rb[i]) begin
        n_fail++;
        $display("FAIL write_rbuf[%0d]: got %h, required %h", i,
                 (i < rbq.size()) ? rbq[i] : 42'h0, exp_rb[i]);
      end
    end
    n_tests++;
    if (issue_cnt != 1 || strobe_split != 0) begin
      n_fail++;
      $display("FAIL write_issue: %0d strobes (%0d split), required 1 (0)", issue_cnt, strobe_split);
    end
    n_tests++;
    if (cap_addr !== 31'h2000_0008 || cap_ctrl !== 22'h00000A || cap_tid !== 6'd3) begin
      n_fail++;
      $display("FAIL write_regs: addr=%h ctrl=%h tid=%0d, required 20000008/00000a/3",
               cap_addr, cap_ctrl, cap_tid);
    end
    n_tests++;
    if (hif.tx_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_wait: tx_valid=%b busy=%b, required 0/1", hif.tx_valid, busy);
    end
    pulse_done(6'd3);
    collect_tx(1, 1'b0);
    n_tests++;
    if (txq.size() < 1 || txq[0] !== 32'h4300_0020) begin
      n_fail++;
      $display("FAIL write_ack: got %h, required 43000020", (txq.size() > 0) ? txq[0] : 32'h0);
    end
    wait_idle();
    $display("[TB] write tid3 buf0 cnt2: %0d rbuf writes, ack done", rbq.size());
  endtask

  task automatic test_read();
    logic [31:0] exp_tx [4];
    logic [21:0] exp_ctrl;
    logic [30:0] exp_addr;
    exp_tx[0] = 32'hA5C3_03FE;
    exp_tx[1] = 32'hA5C3_03FF;
    exp_tx[2] = 32'hA5C3_0000;
    exp_tx[3] = 32'hA5C3_0001;
`ifdef DEBUG_DMA_PARITY_EN
    exp_ctrl = 22'h3FE00D;
    exp_addr = 31'h81;
`else
    exp_ctrl = 22'h3FE00C;
    exp_addr = 31'h80;
`endif
    clear_logs();
    stall_viol = 0;
    send_word(32'h85FF_8035);
    send_word(32'h0000_0100);
    repeat (3) @(negedge gclk);
    n_tests++;
    if (cap_ctrl !== exp_ctrl || cap_addr !== exp_addr || cap_tid !== 6'd5) begin
      n_fail++;
      $display("FAIL read_regs: ctrl=%h addr=%h tid=%0d, required %h/%h/5",
               cap_ctrl, cap_addr, cap_tid, exp_ctrl, exp_addr);
    end
    pulse_done(6'd5);
    collect_tx(4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= txq.size() || txq[i] !== exp_tx[i]) begin
        n_fail++;
        $display("FAIL read_word[%0d]: got %h, required %h", i,
                 (i < txq.size()) ? txq[i] : 32'h0, exp_tx[i]);
      end
    end
    n_tests++;
    if (stall_viol != 0) begin
      n_fail++;
      $display("FAIL read_stall_hold: %0d unstable stalls, required 0", stall_viol);
    end
    wait_idle();
    $display("[TB] read tid5 buf1022 cnt3 with stalls: %0d words", txq.size());
  endtask

  task automatic test_back_to_back();
    clear_logs();
    send_word(32'h8901_4030);
    send_word(32'h0000_0000);
    repeat (2) @(negedge gclk);
    pulse_done(6'd9);
    collect_tx(4, 1'b0);
    n_tests++;
    if (txq.size() != 4 || txq[3] !== 32'hA5C3_0008 || txcyc[3] - txcyc[0] != 3) begin
      n_fail++;
      $display("FAIL back_to_back: last=%h span=%0d, required a5c30008 span 3",
               (txq.size() == 4) ? txq[3] : 32'h0, (txcyc.size() == 4) ? txcyc[3] - txcyc[0] : -1);
    end
    wait_idle();
    $display("[TB] back-to-back read tid9 buf5 cnt3: %0d words", txq.size());
  endtask

  task automatic test_wrong_tid();
    clear_logs();
    send_word(32'h8501_C000);
    send_word(32'h0000_0040);
    dma_done     = 1'b1;
    dma_done_tid = 6'd5;
    @(negedge gclk);
    dma_done_tid = 6'd4;
    @(negedge gclk);
    dma_done     = 1'b0;
    hif.tx_ready = 1'b1;
    repeat (5) @(negedge gclk);
    hif.tx_ready = 1'b0;
    n_tests++;
    if (txq.size() != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wrong_tid_ignored: %0d tx words busy=%b, required 0/1", txq.size(), busy);
    end
    pulse_done(6'd5);
    collect_tx(1, 1'b0);
    n_tests++;
    if (txq.size() < 1 || txq[0] !== 32'hA5C3_0007) begin
      n_fail++;
      $display("FAIL wrong_tid_resp: got %h, required a5c30007", (txq.size() > 0) ? txq[0] : 32'h0);
    end
    wait_idle();
    $display("[TB] tid filter: issue-cycle and tid4 done ignored, tid5 done served");
  endtask

  task automatic test_reserved();
    clear_logs();
    send_word(32'hC000_0000);
    @(negedge gclk);
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reserved_err: err=%b busy=%b, required 1/0", err, busy);
    end
    send_word(32'h4200_0007);
    send_word(32'h0000_0008);
    send_word(32'h1234_5678);
    repeat (2) @(negedge gclk);
    pulse_done(6'd2);
    collect_tx(1, 1'b0);
    n_tests++;
    if (txq.size() < 1 || txq[0] !== 32'h4200_0000 || rbq.size() != 1) begin
      n_fail++;
      $display("FAIL reserved_then_write: ack=%h rbuf=%0d, required 42000000/1",
               (txq.size() > 0) ? txq[0] : 32'h0, rbq.size());
    end
    wait_idle();
    $display("[TB] reserved op sets err, following write completes");
  endtask

  task automatic test_reset_midop();
    int issues_before;
    clear_logs();
    send_word(32'h4600_0020);
    send_word(32'h0000_0100);
    send_word(32'h1111_1111);
    hif.rx_valid = 1'b1;
    hif.rx_data  = 32'h2222_2222;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, err, hif.rx_ready, rbuf_we, cmd_addr_we, hif.tx_valid} !== 6'b0 ||
        rbuf_data !== 32'h0 || cmd_tid !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_midop: busy/err/rdy/rwe/awe/txv=%b rdata=%h tid=%0d, required 0",
               {busy, err, hif.rx_ready, rbuf_we, cmd_addr_we, hif.tx_valid}, rbuf_data, cmd_tid);
    end
    issues_before = issue_cnt;
    @(negedge gclk);
    hif.rx_valid = 1'b0;
    repeat (2) @(negedge gclk);
    rst = 1'b0;
    repeat (3) @(negedge gclk);
    n_tests++;
    if (issue_cnt != issues_before || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_strobe: %0d strobes busy=%b, required 0/0", issue_cnt - issues_before, busy);
    end
    rbq.delete();
    send_word(32'h4719_0013);
    send_word(32'h0000_0200);
    send_word(32'hDDDD_0001);
    send_word(32'hEEEE_0002);
    repeat (2) @(negedge gclk);
    pulse_done(6'd7);
    collect_tx(1, 1'b0);
    n_tests++;
    if (rbq.size() != 2 || rbq[0] !== {10'd100, 32'hDDDD_0001} || rbq[1] !== {10'd101, 32'hEEEE_0002}) begin
      n_fail++;
      $display("FAIL reset_recover_rbuf: %0d writes first=%h, required 2 starting at addr 100",
               rbq.size(), (rbq.size() > 0) ? rbq[0] : 42'h0);
    end
    n_tests++;
    if (txq.size() < 1 || txq[0] !== 32'h4719_0010) begin
      n_fail++;
      $display("FAIL reset_recover_ack: got %h, required 47190010", (txq.size() > 0) ? txq[0] : 32'h0);
    end
    wait_idle();
    $display("[TB] reset during WDATA aborted, new write tid7 buf100 completed");
  endtask

  task automatic test_parity();
    logic [30:0] exp_addr;
    logic [21:0] exp_ctrl;
    logic        exp_err;
`ifdef DEBUG_DMA_PARITY_EN
    exp_addr = 31'h3;
    exp_ctrl = 22'h00200D;
    exp_err  = 1'b1;
`else
    exp_addr = 31'h2;
    exp_ctrl = 22'h00200C;
    exp_err  = 1'b0;
`endif
    clear_logs();
    pflip[3] = 1'b1;
    send_word(32'h8100_8030);
    send_word(32'h0000_0004);
    repeat (2) @(negedge gclk);
    n_tests++;
    if (cap_addr !== exp_addr || cap_ctrl !== exp_ctrl || err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_regs: addr=%h ctrl=%h err=%b, required %h/%h/0",
               cap_addr, cap_ctrl, err, exp_addr, exp_ctrl);
    end
    pulse_done(6'd1);
    collect_tx(4, 1'b1);
    n_tests++;
    if (txq.size() != 4 || txq[1] !== 32'hA5C3_0003 || txq[3] !== 32'hA5C3_0005) begin
      n_fail++;
      $display("FAIL parity_words: %0d words second=%h, required 4 with a5c30003",
               txq.size(), (txq.size() > 1) ? txq[1] : 32'h0);
    end
    wait_idle();
    n_tests++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL parity_err: got %b, required %b", err, exp_err);
    end
    pflip[3] = 1'b0;
    $display("[TB] parity read tid1 buf2 cnt3: err=%b", err);
  endtask

  initial begin
    rst          = 1'b1;
    hif.rx_data  = '0;
    hif.rx_valid = 1'b0;
    hif.tx_ready = 1'b0;
    dma_done     = 1'b0;
    dma_done_tid = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_wrong_tid();
    test_reserved();
    test_reset_midop();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
